// File: rtl/reg_dump_scanner_if.sv
// Byte stream carrying register-dump records from the scanner to a UART/display sink.
// The sink takes a byte on any cycle where out_valid and out_ready are both high.
interface reg_dump_scanner_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/reg_dump_scanner.sv
// Debug register-file dump engine: on halt PC, manual start or watchdog expiry it walks
// reg_sel over every register and streams 5-byte records {idx, word[31:0] MSB first}.
module reg_dump_scanner #(
  parameter logic [31:0] HALT_PC = 32'h0000_0200,
  parameter int unsigned NREGS   = 32,
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [31:0]        pc_i,
  input  logic               start_i,
  output logic [4:0]         reg_sel_o,
  input  logic [31:0]        reg_data_i,
  reg_dump_scanner_if.master stream,
  output logic               busy_o,
  output logic               done_o,
  output logic               timeout_o
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT - 1);
  localparam logic [4:0]      LAST_IDX = 5'(NREGS - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SEL  = 3'd1;
  localparam logic [2:0] S_CAP  = 3'd2;
  localparam logic [2:0] S_SEND = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [4:0]      idx_q, idx_d;
  logic [31:0]     word_q, word_d;
  logic [2:0]      bc_q, bc_d;
  logic [7:0]      out_data_q, out_data_d;
  logic            out_valid_q, out_valid_d;
  logic            timeout_q, timeout_d;
  logic [WD_W-1:0] wd_q, wd_d;

  logic trig_halt, trig_wd, handshake;

  function automatic logic [7:0] rec_byte(input logic [31:0] w, input logic [2:0] n);
    case (n)
      3'd1:    return w[31:24];
      3'd2:    return w[23:16];
      3'd3:    return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

  assign trig_halt = (pc_i == HALT_PC);
  assign trig_wd   = (wd_q == WD_LIMIT);
  assign handshake = out_valid_q & stream.out_ready;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    word_d      = word_q;
    bc_d        = bc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    timeout_d   = timeout_q;
    wd_d        = wd_q;

    case (state_q)
      S_IDLE: begin
        if (!trig_wd) wd_d = wd_q + WD_W'(1);
        // Halt outranks start, which outranks the watchdog; only the watchdog flags timeout.
        if (trig_halt || start_i || trig_wd) begin
          timeout_d = !trig_halt && !start_i;
          idx_d     = 5'd0;
          state_d   = S_SEL;
        end
      end
      S_SEL: state_d = S_CAP;
      S_CAP: begin
        word_d      = reg_data_i;
        bc_d        = 3'd0;
        out_data_d  = {3'b000, idx_q};
        out_valid_d = 1'b1;
        state_d     = S_SEND;
      end
      S_SEND: begin
        if (handshake) begin
          if (bc_q != 3'd4) begin
            bc_d       = bc_q + 3'd1;
            out_data_d = rec_byte(word_q, bc_q + 3'd1);
          end else begin
            out_valid_d = 1'b0;
            if (idx_q == LAST_IDX) begin
              state_d = S_DONE;
            end else begin
              idx_d   = idx_q + 5'd1;
              state_d = S_SEL;
            end
          end
        end
      end
      S_DONE: begin
        if (start_i) begin
          timeout_d = 1'b0;
          idx_d     = 5'd0;
          state_d   = S_SEL;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      idx_q       <= 5'd0;
      word_q      <= 32'd0;
      bc_q        <= 3'd0;
      out_data_q  <= 8'd0;
      out_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      wd_q        <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      word_q      <= word_d;
      bc_q        <= bc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      timeout_q   <= timeout_d;
      wd_q        <= wd_d;
    end
  end

  // reg_sel tracks idx directly so it only moves on record boundaries.
  assign reg_sel_o        = idx_q;
  assign stream.out_data  = out_data_q;
  assign stream.out_valid = out_valid_q;
  assign busy_o           = (state_q == S_SEL) || (state_q == S_CAP) || (state_q == S_SEND);
  assign done_o           = (state_q == S_DONE);
  assign timeout_o        = timeout_q;

endmodule

// File: tb/tb_reg_dump_scanner.sv
// Directed-plus-random bench for reg_dump_scanner: expected byte streams come from a
// per-register record model, and the sink monitor checks stability during stalls.
module tb_reg_dump_scanner;
  localparam logic [31:0] HALT = 32'h0000_0200;
  localparam int NR = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] pc = 32'd0;
  logic [4:0]  reg_sel;
  logic [31:0] reg_data;
  logic        busy, done, timeout;
  logic        rdy = 1'b1;
  logic [31:0] cpu_base = 32'h1000_0000;
  logic [31:0] cpu_step = 32'd1;
  int          rdy_mode = 0;
  int          n_assert = 0;
  int          n_fail = 0;
  logic [7:0]  rx_q[$];

  reg_dump_scanner_if sif ();

  reg_dump_scanner dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .pc_i       (pc),
    .start_i    (start),
    .reg_sel_o  (reg_sel),
    .reg_data_i (reg_data),
    .stream     (sif),
    .busy_o     (busy),
    .done_o     (done),
    .timeout_o  (timeout)
  );

  assign reg_data      = cpu_base + 32'(reg_sel) * cpu_step;
  assign sif.out_ready = rdy;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 6000) begin
      tick(1);
      cyc++;
    end
    check("done_reached", 32'(done), 32'd1);
  endtask

  task automatic check_stream(input string tag);
    logic [7:0]  exp_q[$];
    logic [31:0] w;
    int          bad;
    for (int r = 0; r < NR; r++) begin
      w = cpu_base + 32'(r) * cpu_step;
      exp_q.push_back(8'(r));
      exp_q.push_back(w[31:24]);
      exp_q.push_back(w[23:16]);
      exp_q.push_back(w[15:8]);
      exp_q.push_back(w[7:0]);
    end
    check({tag, "_len"}, 32'(rx_q.size()), 32'(exp_q.size()));
    bad = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) bad++;
    check({tag, "_bad_bytes"}, 32'(bad), 32'd0);
  endtask

  // Sink ready pattern: 0 = always ready, 1 = 1,0,0,1 repeating, 2 = random.
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       rdy = 1'b1;
        1:       rdy = ((ph % 4) == 0) || ((ph % 4) == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      ph++;
    end
  end

  // Sink monitor: records accepted bytes and checks that stalled outputs hold.
  initial begin
    logic       prev_stall;
    logic [7:0] prev_data;
    logic [4:0] prev_sel;
    prev_stall = 1'b0;
    prev_data  = 8'd0;
    prev_sel   = 5'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", 32'(sif.out_valid), 32'd1);
          check("stall_data", 32'(sif.out_data), 32'(prev_data));
          check("stall_sel", 32'(reg_sel), 32'(prev_sel));
        end
        if (sif.out_valid && rdy) rx_q.push_back(sif.out_data);
        prev_stall = sif.out_valid && !rdy;
        prev_data  = sif.out_data;
        prev_sel   = reg_sel;
      end
    end
  end

  initial begin
    int cyc;
    int n;

    // Reset values
    tick(3);
    check("rst_reg_sel", 32'(reg_sel), 32'd0);
    check("rst_out_data", 32'(sif.out_data), 32'd0);
    check("rst_out_valid", 32'(sif.out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    rst = 1'b0;

    // Halt trigger around cycle 20, sink always ready
    rx_q.delete();
    tick(19);
    pc = HALT;
    tick(1);
    pc = 32'd0;
    check("halt_busy", 32'(busy), 32'd1);
    check("halt_reg_sel", 32'(reg_sel), 32'd0);
    check("halt_timeout", 32'(timeout), 32'd0);
    wait_done(cyc);
    check("halt_latency", 32'(cyc), 32'd224);
    check("halt_timeout_end", 32'(timeout), 32'd0);
    check_stream("halt");

    // DONE ignores the halt PC
    pc = HALT;
    tick(5);
    pc = 32'd0;
    check("done_hold", 32'(done), 32'd1);
    check("done_no_busy", 32'(busy), 32'd0);
    check("done_no_bytes", 32'(rx_q.size()), 32'd160);

    // Re-arm from DONE with 1,0,0,1 backpressure
    cpu_base = $urandom;
    cpu_step = $urandom;
    rdy_mode = 1;
    rx_q.delete();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("rearm_done_clr", 32'(done), 32'd0);
    check("rearm_busy", 32'(busy), 32'd1);
    check("rearm_timeout", 32'(timeout), 32'd0);
    wait_done(cyc);
    check_stream("bp");

    // Watchdog with random backpressure
    rst = 1'b1;
    rdy_mode = 2;
    tick(2);
    rst = 1'b0;
    rx_q.delete();
    cpu_base = $urandom;
    cpu_step = $urandom;
    cyc = 0;
    while (busy !== 1'b1 && cyc < 1200) begin
      tick(1);
      cyc++;
    end
    check("wd_trigger_edge", 32'(cyc), 32'd1000);
    check("wd_timeout", 32'(timeout), 32'd1);
    wait_done(cyc);
    check("wd_timeout_end", 32'(timeout), 32'd1);
    check_stream("wd");

    // Start in DONE clears timeout; a start pulse mid-scan is ignored
    rdy_mode = 0;
    rx_q.delete();
    cpu_base = $urandom;
    cpu_step = $urandom;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("restart_timeout_clr", 32'(timeout), 32'd0);
    check("restart_done_clr", 32'(done), 32'd0);
    n = $urandom_range(10, 150);
    tick(n);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    wait_done(cyc);
    check("ignore_latency", 32'(n + 1 + cyc), 32'd224);
    check_stream("ignore");

    // Reset mid-scan at register 7, byte 2
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    rx_q.delete();
    cpu_base = 32'h1000_0000;
    cpu_step = 32'd1;
    pc = HALT;
    tick(1);
    pc = 32'd0;
    cyc = 0;
    while (rx_q.size() < 37 && cyc < 1000) begin
      tick(1);
      cyc++;
    end
    check("mid_reg_sel", 32'(reg_sel), 32'd7);
    check("mid_out_data", 32'(sif.out_data), 32'h00);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("mid_rst_valid", 32'(sif.out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_reg_sel", 32'(reg_sel), 32'd0);

    // Restart with start and halt PC together: one scan, no timeout
    rx_q.delete();
    cpu_base = $urandom;
    start = 1'b1;
    pc = HALT;
    tick(1);
    start = 1'b0;
    pc = 32'd0;
    check("both_busy", 32'(busy), 32'd1);
    check("both_timeout", 32'(timeout), 32'd0);
    wait_done(cyc);
    check("both_latency", 32'(cyc), 32'd224);
    check_stream("both");
    tick(20);
    check("both_single", 32'(rx_q.size()), 32'd160);

    // Halt PC on the same cycle the watchdog reaches its limit
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    rx_q.delete();
    tick(999);
    pc = HALT;
    tick(1);
    pc = 32'd0;
    check("simul_busy", 32'(busy), 32'd1);
    check("simul_timeout", 32'(timeout), 32'd0);
    wait_done(cyc);
    check_stream("simul");
    tick(30);
    check("simul_single", 32'(rx_q.size()), 32'd160);
    check("simul_done", 32'(done), 32'd1);
    check("simul_timeout_end", 32'(timeout), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_dump_scanner.md
# reg_dump_scanner

Hardware register-file dump engine for the pipelined MIPS system. It sits beside `sccomp` on the debug port. It watches the CPU PC for the halt address, or a watchdog timeout, or a manual start. It then walks `reg_sel` through every architectural register, captures `reg_data`, and streams each register out as a 5-byte record over a valid/ready byte interface, for use by a UART or display sink.

## Interface
- `HALT_PC`, 32'h00000200, PC value that marks end of program and triggers a scan
- `NREGS`, 32, number of registers scanned (indices 0..NREGS-1, NREGS ≤ 32)
- `TIMEOUT`, 1000, idle-cycle watchdog limit that forces a scan if the halt PC is never reached
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `pc`  in  32  current CPU PC
- `start`  in  1  manual scan request (single-cycle pulse or level)
- `reg_sel`  out  5  register index driven to the CPU debug port
- `reg_data`  in  32  CPU debug read data; combinational function of `reg_sel`
- `out_data`  out  8  stream byte
- `out_valid`  out  1  `out_data` valid
- `out_ready`  in  1  sink accepts a byte when `out_valid & out_ready`
- `busy`  out  1  scan in progress
- `done`  out  1  scan complete; held
- `timeout`  out  1  the last scan was triggered by the watchdog

## Operation
- States: IDLE, SEL, CAP, SEND, DONE.
- IDLE:
  - Watchdog counter `wd` counts IDLE cycles from reset.
  - Trigger priority: `pc==HALT_PC` first, then `start`, then `wd==TIMEOUT-1`.
  - A watchdog trigger sets `timeout=1`. The other triggers clear it.
  - On trigger: `idx<=0`, `reg_sel<=0`, go to SEL.
- SEL: one settle cycle for `reg_data`, then go to CAP.
- CAP:
  - Latch `reg_data` into `word`.
  - Load byte counter `bc<=0`.
  - Drive `out_data={3'b0,idx}`, `out_valid<=1`, then go to SEND.
- SEND:
  - Record format: byte 0 = `{3'b0,idx}`, bytes 1..4 = `word[31:24]`, `[23:16]`, `[15:8]`, `[7:0]`.
  - On handshake with `bc<4`: `bc++`, present the next byte.
  - On handshake with `bc==4`:
    - If `idx==NREGS-1`: `out_valid<=0`, go to DONE.
    - Otherwise: `idx++`, `reg_sel<=idx+1`, `out_valid<=0`, go to SEL.
- DONE:
  - `done=1`, `busy=0`.
  - `pc` and the watchdog are ignored.
  - `start` begins a new scan: clears `done` and `timeout`, same entry as the IDLE trigger.
- `busy=1` in SEL, CAP and SEND.
- `start` is ignored while busy.
- Register 0 is scanned like any other register; its value is whatever the CPU returns.
- `wd` saturates and does not advance outside IDLE. Auto triggers fire at most once per reset.

## Timing
- Reset values: `reg_sel=0`, `out_data=0`, `out_valid=0`, `busy=0`, `done=0`, `timeout=0`, `wd=0`, state IDLE.
- `rst` mid-scan aborts at the next edge to reset values. No partial record is completed.
- Trigger evaluation is registered: SEL is entered on the edge that samples the trigger.
- `reg_data` is sampled exactly 2 edges after `reg_sel` changes (the SEL edge, then the CAP edge).
- With `out_ready` held high, each register costs 7 cycles (SEL 1, CAP 1, SEND 5).
  - `done` rises 32×7 = 224 cycles after the trigger edge.
- While `out_valid=1` and `out_ready=0`, `out_data`, `idx` and `reg_sel` must hold stable. `out_valid` must not drop.
- `out_valid` deasserts for at least 2 cycles between records (SEL, CAP).
- Watchdog with `pc` never matching and no `start`: trigger on the TIMEOUT-th IDLE cycle after reset release, i.e. edge 1000 with the default.
- A `pc` match and the watchdog limit in the same cycle: halt wins, `timeout=0`.
- `start` and a `pc` match in the same cycle: a single scan, `timeout=0`.

## Test plan
- Halt trigger:
  - Stimulus: CPU model returns `reg_data = 32'h1000_0000 + reg_sel`; drive `pc=32'h200` at cycle 20; `out_ready=1`.
  - Response: 160 bytes; the first record is `00 10 00 00 00`, the last is `1F 10 00 00 1F`; `done` rises 224 cycles after the trigger; `timeout=0`.
- Watchdog:
  - Stimulus: `pc` held at 32'h0; no `start`.
  - Response: scan begins on IDLE cycle 1000; `timeout=1`; the 160-byte stream completes.
- Backpressure:
  - Stimulus: `out_ready` toggles 1,0,0,1 repeating.
  - Response: no byte is lost or duplicated, and `out_data` is stable during every stall; the byte sequence is identical to the halt test.
- Reset mid-scan:
  - Stimulus: assert `rst` for one cycle during register 7, byte 2.
  - Response: next cycle has `out_valid=0`, `busy=0`, `reg_sel=0`; a new halt trigger restarts the scan from `idx 0`.
- Re-arm and ignore:
  - Stimulus: `start` pulse while busy; then `start` in DONE.
  - Response: the first pulse has no effect. The second clears `done`, starts a fresh 160-byte scan, and leaves `timeout=0`.
- Simultaneous triggers:
  - Stimulus: `pc==HALT_PC` on the same cycle `wd` reaches 999.
  - Response: exactly one scan; `timeout=0`.
